// File: rtl/spmmio_spitarget_pkg.sv
// rtl/spmmio_spitarget_pkg.sv - shared register map, bit positions and CRC polynomials
package spmmio_spitarget_pkg;

    typedef logic [0:7] spi_byte_t;

    localparam logic [0:3] ADR_CTRL = 4'd0;
    localparam logic [0:3] ADR_CRC  = 4'd1;

    // Control/status bit positions, MSB-first numbering as seen on q/d
    localparam int unsigned BIT_IE_RX       = 8;
    localparam int unsigned BIT_IE_DESEL    = 9;
    localparam int unsigned BIT_SEL_FLAG    = 12;
    localparam int unsigned BIT_DESEL_FLAG  = 13;
    localparam int unsigned BIT_OVERRUN     = 14;
    localparam int unsigned BIT_UNDERRUN    = 15;
    localparam int unsigned BIT_SELECTED    = 19;
    localparam int unsigned BIT_TX_VALID    = 21;
    localparam int unsigned BIT_RX_FULL     = 23;

    localparam logic [0:6]  CRC7_POLY  = 7'h09;
    localparam logic [0:15] CRC16_POLY = 16'h1021;

endpackage

// File: rtl/spmmio_spitarget_edge_sync.sv
// rtl/spmmio_spitarget_edge_sync.sv - multi-flop synchronizer with rise/fall pulses
module spi_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spmmio_spitarget.sv
// rtl/spmmio_spitarget.sv - SPI mode-0 target with MMIO registers and rx CRC7 / tx CRC16
module spmmio_spitarget
    import spmmio_spitarget_pkg::*;
#(
    parameter logic [7:0] FILL_BYTE   = 8'hFF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:3]  adr,
    input  logic        cs,
    input  logic [0:3]  sel,
    input  logic        we,
    input  logic [0:31] d,
    output logic [0:31] q,
    output logic        irq,
    input  logic        spi_ss_n,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe
);

    logic sck_level, sck_rise, sck_fall;
    logic ss_level, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic mosi_s;

    spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (spi_sck),
        .level_o (sck_level),
        .rise_o  (sck_rise),
        .fall_o  (sck_fall)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES)) u_ss_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (spi_ss_n),
        .level_o (ss_level),
        .rise_o  (ss_rise),
        .fall_o  (ss_fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    // mosi has the same depth as sck's level, so it is aligned with the rise pulse
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    logic        armed_q, armed_d;
    logic        selected_q, selected_d;
    logic        started_q, started_d;
    logic        ie_rx_q, ie_rx_d;
    logic        ie_desel_q, ie_desel_d;
    logic        sel_flag_q, sel_flag_d;
    logic        desel_flag_q, desel_flag_d;
    logic        overrun_q, overrun_d;
    logic        underrun_q, underrun_d;
    logic        tx_valid_q, tx_valid_d;
    logic        rx_full_q, rx_full_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [0:6]  sr_in_q, sr_in_d;
    spi_byte_t   rx_data_q, rx_data_d;
    spi_byte_t   tx_data_q, tx_data_d;
    spi_byte_t   sr_out_q, sr_out_d;
    logic [0:6]  crc7_q, crc7_d;
    logic [0:15] crc16_q, crc16_d;

    logic wr_ctrl, wr_crc, clr_rx;
    logic select_ev, desel_ev, sck_rise_sel, sck_fall_sel, reload;
    logic crc7_fb, crc16_fb;

    assign wr_ctrl      = cs & we & (adr == ADR_CTRL);
    assign wr_crc       = cs & we & (adr == ADR_CRC);
    assign clr_rx       = wr_ctrl & sel[2] & d[BIT_RX_FULL];
    assign select_ev    = ss_fall & armed_q;
    assign desel_ev     = ss_rise & selected_q;
    assign sck_rise_sel = sck_rise & selected_q;
    assign sck_fall_sel = sck_fall & selected_q;
    assign reload       = select_ev | (sck_fall_sel & (bitcnt_q == 3'd0) & started_q);
    assign crc7_fb      = crc7_q[0] ^ mosi_s;
    assign crc16_fb     = crc16_q[0] ^ sr_out_q[0];

    always_comb begin
        armed_d      = armed_q | ss_level;
        selected_d   = selected_q;
        started_d    = started_q;
        ie_rx_d      = ie_rx_q;
        ie_desel_d   = ie_desel_q;
        sel_flag_d   = sel_flag_q;
        desel_flag_d = desel_flag_q;
        overrun_d    = overrun_q;
        underrun_d   = underrun_q;
        tx_valid_d   = tx_valid_q;
        rx_full_d    = rx_full_q;
        bitcnt_d     = bitcnt_q;
        sr_in_d      = sr_in_q;
        rx_data_d    = rx_data_q;
        tx_data_d    = tx_data_q;
        sr_out_d     = sr_out_q;
        crc7_d       = crc7_q;
        crc16_d      = crc16_q;

        // Firmware clears are applied first so that same-cycle hardware sets win
        if (wr_ctrl && sel[1]) begin
            ie_rx_d    = d[BIT_IE_RX];
            ie_desel_d = d[BIT_IE_DESEL];
            if (d[BIT_SEL_FLAG])   sel_flag_d   = 1'b0;
            if (d[BIT_DESEL_FLAG]) desel_flag_d = 1'b0;
            if (d[BIT_OVERRUN])    overrun_d    = 1'b0;
            if (d[BIT_UNDERRUN])   underrun_d   = 1'b0;
        end
        if (clr_rx) begin
            rx_full_d = 1'b0;
        end

        if (select_ev) begin
            selected_d = 1'b1;
            started_d  = 1'b0;
            sel_flag_d = 1'b1;
            bitcnt_d   = 3'd0;
            crc7_d     = '0;
        end

        if (sck_rise_sel) begin
            sr_in_d   = {sr_in_q[1:6], mosi_s};
            crc7_d    = {crc7_q[1:6], 1'b0} ^ ({7{crc7_fb}} & CRC7_POLY);
            crc16_d   = {crc16_q[1:15], 1'b0} ^ ({16{crc16_fb}} & CRC16_POLY);
            bitcnt_d  = bitcnt_q + 3'd1;
            started_d = 1'b1;
            if (bitcnt_q == 3'd7) begin
                rx_data_d = {sr_in_q, mosi_s};
                rx_full_d = 1'b1;
                if (rx_full_q && !clr_rx) begin
                    overrun_d = 1'b1;
                end
            end
        end

        if (sck_fall_sel && bitcnt_q != 3'd0) begin
            sr_out_d = {sr_out_q[1:7], 1'b1};
        end

        if (reload) begin
            if (tx_valid_q) begin
                sr_out_d   = tx_data_q;
                tx_valid_d = 1'b0;
            end else begin
                sr_out_d   = FILL_BYTE;
                underrun_d = 1'b1;
            end
        end

        if (desel_ev) begin
            selected_d   = 1'b0;
            desel_flag_d = 1'b1;
            bitcnt_d     = 3'd0;
        end

        // Writes after the reload: a byte written during a reload stays queued
        if (wr_ctrl && sel[3]) begin
            tx_data_d  = d[24:31];
            tx_valid_d = 1'b1;
        end

        if (wr_crc) begin
            if (sel[0]) crc7_d        = d[0:6];
            if (sel[2]) crc16_d[0:7]  = d[16:23];
            if (sel[3]) crc16_d[8:15] = d[24:31];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            armed_q      <= 1'b0;
            selected_q   <= 1'b0;
            started_q    <= 1'b0;
            ie_rx_q      <= 1'b0;
            ie_desel_q   <= 1'b0;
            sel_flag_q   <= 1'b0;
            desel_flag_q <= 1'b0;
            overrun_q    <= 1'b0;
            underrun_q   <= 1'b0;
            tx_valid_q   <= 1'b0;
            rx_full_q    <= 1'b0;
            bitcnt_q     <= 3'd0;
            sr_in_q      <= '0;
            rx_data_q    <= '0;
            tx_data_q    <= '0;
            sr_out_q     <= FILL_BYTE;
            crc7_q       <= '0;
            crc16_q      <= '0;
        end else begin
            armed_q      <= armed_d;
            selected_q   <= selected_d;
            started_q    <= started_d;
            ie_rx_q      <= ie_rx_d;
            ie_desel_q   <= ie_desel_d;
            sel_flag_q   <= sel_flag_d;
            desel_flag_q <= desel_flag_d;
            overrun_q    <= overrun_d;
            underrun_q   <= underrun_d;
            tx_valid_q   <= tx_valid_d;
            rx_full_q    <= rx_full_d;
            bitcnt_q     <= bitcnt_d;
            sr_in_q      <= sr_in_d;
            rx_data_q    <= rx_data_d;
            tx_data_q    <= tx_data_d;
            sr_out_q     <= sr_out_d;
            crc7_q       <= crc7_d;
            crc16_q      <= crc16_d;
        end
    end

    always_comb begin
        q = '0;
        if (cs && adr == ADR_CTRL) begin
            q[BIT_IE_RX]      = ie_rx_q;
            q[BIT_IE_DESEL]   = ie_desel_q;
            q[BIT_SEL_FLAG]   = sel_flag_q;
            q[BIT_DESEL_FLAG] = desel_flag_q;
            q[BIT_OVERRUN]    = overrun_q;
            q[BIT_UNDERRUN]   = underrun_q;
            q[BIT_SELECTED]   = selected_q;
            q[BIT_TX_VALID]   = tx_valid_q;
            q[BIT_RX_FULL]    = rx_full_q;
            q[24:31]          = rx_data_q;
        end else if (cs && adr == ADR_CRC) begin
            q[0:7]   = {crc7_q, 1'b1};
            q[16:31] = crc16_q;
        end
    end

    assign irq         = (rx_full_q & ie_rx_q) | (desel_flag_q & ie_desel_q);
    assign spi_miso    = sr_out_q[0];
    assign spi_miso_oe = selected_q;

    logic unused_bits;
    assign unused_bits = ^{d[7], d[10:11], sck_level};

endmodule

// File: tb/tb_spmmio_spitarget.sv
// tb/tb_spmmio_spitarget.sv - scoreboard bench for spmmio_spitarget
module tb_spmmio_spitarget;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:3]  adr;
    logic        cs;
    logic [0:3]  sel;
    logic        we;
    logic [0:31] d;
    logic [0:31] q;
    logic        irq;
    logic        spi_ss_n;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;

    always #5 clk = ~clk;

    spmmio_spitarget #(.FILL_BYTE(8'hFF), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .adr         (adr),
        .cs          (cs),
        .sel         (sel),
        .we          (we),
        .d           (d),
        .q           (q),
        .irq         (irq),
        .spi_ss_n    (spi_ss_n),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe)
    );

    typedef struct {
        string       name;
        logic        pins;
        logic [31:0] mask;
        logic [31:0] exp;
    } rd_exp_t;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } miso_exp_t;

    rd_exp_t     rd_q[$];
    miso_exp_t   miso_q[$];
    rd_exp_t     mon_e;
    miso_exp_t   mon_me;
    logic [31:0] mon_act;
    logic [7:0]  cap;
    int          ncap = 0;
    int          checks = 0;
    int          errors = 0;
    logic        req = 1'b0;
    logic        mon_en = 1'b1;

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
        end
    endtask

    task automatic clks(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mmio_wr(logic [0:3] a, logic [0:3] s, logic [31:0] v);
        @(posedge clk); #1;
        cs = 1'b1; we = 1'b1; adr = a; sel = s; d = v;
        @(posedge clk); #1;
        cs = 1'b0; we = 1'b0; sel = 4'b0000; d = '0;
    endtask

    task automatic expect_rd(logic [0:3] a, logic [31:0] m, logic [31:0] e, string n);
        @(posedge clk); #1;
        cs = 1'b1; we = 1'b0; adr = a;
        rd_q.push_back('{n, 1'b0, m, e});
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; cs = 1'b0;
    endtask

    // pins word is {irq, spi_miso_oe, spi_miso}
    task automatic expect_pins(logic [2:0] m, logic [2:0] e, string n);
        @(posedge clk); #1;
        rd_q.push_back('{n, 1'b1, {29'd0, m}, {29'd0, e}});
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic ss_low();
        spi_ss_n = 1'b0;
        clks(6);
    endtask

    task automatic ss_high();
        clks(2);
        spi_ss_n = 1'b1;
        clks(6);
    endtask

    task automatic spi_bits(logic [7:0] mo, int n);
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = mo[i];
            clks(4);
            spi_sck = 1'b1;
            clks(4);
            spi_sck = 1'b0;
        end
    endtask

    task automatic spi_byte(logic [7:0] mo, logic [7:0] exp_miso, string n);
        if (mon_en) miso_q.push_back('{n, exp_miso});
        spi_bits(mo, 8);
    endtask

    initial forever begin
        @(negedge clk);
        if (req) begin
            if (rd_q.size() == 0) begin
                chk("rd_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e   = rd_q.pop_front();
                mon_act = mon_e.pins ? {29'd0, irq, spi_miso_oe, spi_miso} : q;
                chk(mon_e.name, mon_act & mon_e.mask, mon_e.exp);
            end
        end
    end

    initial forever begin
        @(posedge spi_sck or posedge spi_ss_n);
        if (spi_ss_n || !mon_en) begin
            ncap = 0;
        end else begin
            cap = {cap[6:0], spi_miso};
            ncap++;
            if (ncap == 8) begin
                ncap = 0;
                if (miso_q.size() == 0) begin
                    chk("miso_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_me = miso_q.pop_front();
                    chk(mon_me.name, {24'd0, cap}, {24'd0, mon_me.exp});
                end
            end
        end
    end

    initial begin
        repeat (97000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cs = 1'b0; we = 1'b0; adr = '0; sel = '0; d = '0;
        spi_ss_n = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
        clks(4);
        reset = 1'b0;
        clks(6);

        expect_rd(4'd0, 32'hFFFF_FFFF, 32'h0000_0000, "reset_ctrl");
        expect_rd(4'd1, 32'hFFFF_FFFF, 32'h0100_0000, "reset_crc");
        expect_pins(3'b111, 3'b001, "reset_pins");

        // CMD0 frame with nothing queued
        ss_low();
        spi_byte(8'h40, 8'hFF, "cmd0_miso0");
        clks(4);
        expect_rd(4'd0, 32'hFFFF_FFFF, 32'h0009_1140, "cmd0_first_byte");
        expect_pins(3'b010, 3'b010, "oe_selected");
        for (int i = 1; i < 5; i++) begin
            mmio_wr(4'd0, 4'b0010, 32'h0000_0100);
            spi_byte(8'h00, 8'hFF, "cmd0_miso");
            clks(4);
        end
        expect_rd(4'd0, 32'h0000_01FF, 32'h0000_0100, "cmd0_last_rx");
        expect_rd(4'd0, 32'h0001_0000, 32'h0001_0000, "cmd0_underrun");
        expect_rd(4'd1, 32'hFF00_0000, 32'h9500_0000, "cmd0_crc7");
        ss_high();
        expect_rd(4'd0, 32'h0004_1000, 32'h0004_0000, "cmd0_desel");
        mmio_wr(4'd0, 4'b0110, 32'h000F_0100);
        expect_rd(4'd0, 32'hFFFF_FFFF, 32'h0000_0000, "flags_cleared");

        // Queued tx byte
        mmio_wr(4'd0, 4'b0001, 32'h0000_00A5);
        expect_rd(4'd0, 32'hFFFF_FFFF, 32'h0000_0400, "tx_queued");
        ss_low();
        spi_byte(8'h3C, 8'hA5, "tx_a5_miso");
        clks(4);
        expect_rd(4'd0, 32'hFFFF_FFFF, 32'h0009_113C, "tx_after_byte");
        mmio_wr(4'd0, 4'b0100, 32'h0001_0000);
        expect_rd(4'd0, 32'h0001_0000, 32'h0000_0000, "underrun_w1c");

        // Overrun
        mmio_wr(4'd0, 4'b0010, 32'h0000_0100);
        spi_byte(8'h11, 8'hFF, "ovr_miso0");
        spi_byte(8'h22, 8'hFF, "ovr_miso1");
        clks(4);
        expect_rd(4'd0, 32'h0002_01FF, 32'h0002_0122, "overrun_set");
        mmio_wr(4'd0, 4'b0100, 32'h0002_0000);
        expect_rd(4'd0, 32'h0002_0000, 32'h0000_0000, "overrun_w1c");
        ss_high();
        mmio_wr(4'd0, 4'b0110, 32'h000F_0100);

        mmio_wr(4'd1, 4'b1011, 32'h5A00_1234);
        expect_rd(4'd1, 32'hFFFF_FFFF, 32'h5B00_1234, "crc_write");

        // 512 queued zero bytes
        mmio_wr(4'd1, 4'b0011, 32'h0000_0000);
        mmio_wr(4'd0, 4'b0001, 32'h0000_0000);
        ss_low();
        for (int i = 0; i < 512; i++) begin
            if (i > 0) clks(3);
            if (i < 511) mmio_wr(4'd0, 4'b0001, 32'h0000_0000);
            spi_byte(8'hFF, 8'h00, "blk_zero_miso");
        end
        ss_high();
        expect_rd(4'd1, 32'h0000_FFFF, 32'h0000_0000, "crc16_zeros");

        // 512 fill bytes
        mmio_wr(4'd1, 4'b0011, 32'h0000_0000);
        ss_low();
        for (int i = 0; i < 512; i++) begin
            spi_byte(8'h00, 8'hFF, "blk_fill_miso");
        end
        ss_high();
        expect_rd(4'd1, 32'h0000_FFFF, 32'h0000_7FA1, "crc16_ones");

        // Deselect interrupt after a partial byte
        mmio_wr(4'd0, 4'b0110, 32'h004F_0100);
        expect_rd(4'd0, 32'h00FF_FF00, 32'h0040_0000, "ie_desel_set");
        expect_pins(3'b100, 3'b000, "irq_idle");
        ss_low();
        spi_byte(8'h77, 8'hFF, "desel_miso");
        spi_bits(8'hE0, 3);
        ss_high();
        expect_rd(4'd0, 32'h0044_11FF, 32'h0044_0177, "desel_partial");
        expect_pins(3'b110, 3'b100, "desel_irq");
        mmio_wr(4'd0, 4'b0100, 32'h0044_0000);
        expect_pins(3'b100, 3'b000, "desel_irq_cleared");
        mmio_wr(4'd0, 4'b0100, 32'h0080_0000);
        expect_pins(3'b100, 3'b100, "rx_irq");
        mmio_wr(4'd0, 4'b0010, 32'h0000_0100);
        expect_pins(3'b100, 3'b000, "rx_irq_cleared");
        mmio_wr(4'd0, 4'b0110, 32'h000F_0100);

        // Reset mid-byte with select held low
        mon_en = 1'b0;
        ss_low();
        spi_bits(8'hFF, 3);
        reset = 1'b1;
        clks(2);
        reset = 1'b0;
        clks(4);
        expect_pins(3'b011, 3'b001, "reset_mid_pins");
        spi_bits(8'hAB, 8);
        clks(4);
        expect_rd(4'd0, 32'hFFFF_FFFF, 32'h0000_0000, "ignored_after_reset");
        ss_high();
        mon_en = 1'b1;
        ss_low();
        spi_byte(8'h5A, 8'hFF, "resync_miso");
        clks(4);
        expect_rd(4'd0, 32'h0000_11FF, 32'h0000_115A, "resync_rx");
        ss_high();

        clks(10);
        chk("rd_queue_drained", rd_q.size(), 32'd0);
        chk("miso_queue_drained", miso_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
